// File: rtl/axis_s_rx.sv
// AXI4-Stream receiver (slave end). Incoming beats are buffered in a small
// FIFO and presented to the local consumer as a first-word-fall-through read
// port. Packet boundaries (tlast) are tracked with a per-packet beat count
// and a one-cycle done pulse.
module axis_s_rx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     tvalid,
    output logic                     tready,
    input  logic [DATA_W-1:0]        tdata,
    input  logic                     tlast,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_last,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     pkt_done,
    output logic [CNT_W-1:0]         pkt_beats,
    output logic                     rd_err
);

    localparam int ADDR = $clog2(DEPTH);
    localparam logic [ADDR:0]    DEPTH_L = (ADDR+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Storage: {tlast, tdata} per entry; contents are don't-care until written.
    logic [DATA_W:0] mem_q [DEPTH];

    logic [ADDR:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]      level_d;
    logic               tready_q, tready_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   pkt_beats_q, pkt_beats_d;
    logic               pkt_done_q, pkt_done_d;
    logic               rd_err_q, rd_err_d;

    logic               accept_s;
    logic               pop_s;
    logic               empty_s;
    logic               full_s;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]) &&
                      (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]);
    assign accept_s = tvalid & tready_q;
    assign pop_s    = rd_en & ~empty_s;

    // Pointer advance and the registered-ready lookahead on next-state level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + (ADDR+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + (ADDR+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d  = wr_ptr_d - rd_ptr_d;
        tready_d = (level_d != DEPTH_L);
    end

    // Packet tracking: saturating beat count, result latched on tlast.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        pkt_beats_d = pkt_beats_q;
        pkt_done_d  = 1'b0;
        if (accept_s && tlast) begin
            beat_cnt_d  = {CNT_W{1'b0}};
            pkt_done_d  = 1'b1;
            if (beat_cnt_q == CNT_MAX) begin
                pkt_beats_d = CNT_MAX;
            end else begin
                pkt_beats_d = beat_cnt_q + CNT_W'(1);
            end
        end else if (accept_s) begin
            if (beat_cnt_q == CNT_MAX) begin
                beat_cnt_d = CNT_MAX;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        rd_err_d = rd_err_q | (rd_en & empty_s);
    end

    // Control state: everything drops immediately on reset assertion.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tready_q    <= 1'b0;
            beat_cnt_q  <= '0;
            pkt_beats_q <= '0;
            pkt_done_q  <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tready_q    <= tready_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_beats_q <= pkt_beats_d;
            pkt_done_q  <= pkt_done_d;
            rd_err_q    <= rd_err_d;
        end
    end

    // FIFO storage write; no reset so it maps onto plain RAM/flops.
    always_ff @(posedge aclk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q[ADDR-1:0]] <= {tlast, tdata};
        end
    end

    assign {dout_last, dout} = mem_q[rd_ptr_q[ADDR-1:0]];
    assign tready    = tready_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_beats = pkt_beats_q;
    assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_axis_s_rx.sv
// Directed bench for axis_s_rx: a queue scoreboard models the FIFO contents,
// ready, packet tracking and the sticky read error, and every cycle the DUT
// outputs are compared against it.
module tb_axis_s_rx;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              aclk = 1'b0;
    logic              areset_n = 1'b0;
    logic              tvalid = 1'b0;
    logic              tready;
    logic [DATA_W-1:0] tdata = '0;
    logic              tlast = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_last;
    logic              empty;
    logic              full;
    logic [2:0]        level;
    logic              pkt_done;
    logic [CNT_W-1:0]  pkt_beats;
    logic              rd_err;

    axis_s_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .aclk(aclk), .areset_n(areset_n), .tvalid(tvalid), .tready(tready),
        .tdata(tdata), .tlast(tlast), .rd_en(rd_en), .dout(dout),
        .dout_last(dout_last), .empty(empty), .full(full), .level(level),
        .pkt_done(pkt_done), .pkt_beats(pkt_beats), .rd_err(rd_err)
    );

    always #5 aclk = ~aclk;

    // Scoreboard / model state
    logic [DATA_W:0]  sb_q[$];
    logic             m_tready = 1'b0;
    logic             m_done   = 1'b0;
    logic [CNT_W-1:0] m_pkt    = '0;
    logic [CNT_W-1:0] m_beat   = '0;
    logic             m_rderr  = 1'b0;
    logic             last_acc = 1'b0;
    int               done_seen = 0;
    int               total  = 0;
    int               passed = 0;
    int               failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " tready"},    64'(tready),    64'(m_tready));
        chk({tag, " empty"},     64'(empty),     64'(sb_q.size() == 0));
        chk({tag, " full"},      64'(full),      64'(sb_q.size() == DEPTH));
        chk({tag, " level"},     64'(level),     64'(sb_q.size()));
        chk({tag, " pkt_done"},  64'(pkt_done),  64'(m_done));
        chk({tag, " pkt_beats"}, 64'(pkt_beats), 64'(m_pkt));
        chk({tag, " rd_err"},    64'(rd_err),    64'(m_rderr));
        if (sb_q.size() != 0) begin
            chk({tag, " dout"}, 64'({dout_last, dout}), 64'(sb_q[0]));
        end
        if (pkt_done === 1'b1) done_seen++;
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input string tag, input logic tv, input logic [DATA_W-1:0] td,
                        input logic tl, input logic re);
        logic acc, pop;
        check_all(tag);
        tvalid = tv; tdata = td; tlast = tl; rd_en = re;
        acc = tv & m_tready;
        pop = re & (sb_q.size() != 0);
        if (re && sb_q.size() == 0) m_rderr = 1'b1;
        if (pop) void'(sb_q.pop_front());
        if (acc) sb_q.push_back({tl, td});
        m_done = acc & tl;
        if (acc && tl) begin
            m_pkt  = (m_beat == {CNT_W{1'b1}}) ? m_beat : m_beat + CNT_W'(1);
            m_beat = '0;
        end else if (acc) begin
            m_beat = (m_beat == {CNT_W{1'b1}}) ? m_beat : m_beat + CNT_W'(1);
        end
        m_tready = (sb_q.size() != DEPTH);
        last_acc = acc;
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_tready = 1'b0; m_done = 1'b0; m_pkt = '0; m_beat = '0; m_rderr = 1'b0;
    endtask

    // Asynchronous reset pulse of one clock, checked immediately on assertion.
    task automatic do_reset(input string tag);
        areset_n = 1'b0;
        tvalid = 1'b0; rd_en = 1'b0; tlast = 1'b0;
        #1;
        model_clear();
        check_all({tag, " async"});
        @(posedge aclk);
        @(negedge aclk);
        check_all({tag, " held"});
        areset_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (sb_q.size() != 0 && g < 20) begin
            step(tag, 1'b0, '0, 1'b0, 1'b1);
            g++;
        end
        chk({tag, " drained"}, 64'(sb_q.size()), 64'(0));
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int i, g, d0;
        logic [DATA_W-1:0] rd;
        @(negedge aclk);
        do_reset("reset");

        // T1: single-beat packet
        step("t1a", 1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
        chk("t1 first edge stall", 64'(last_acc), 64'(0));
        step("t1b", 1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
        step("t1c", 1'b0, '0, 1'b0, 1'b0);
        chk("t1 dout", 64'(dout), 64'(32'hA5A5_0001));
        chk("t1 pkt_beats", 64'(pkt_beats), 64'(1));
        step("t1d", 1'b0, '0, 1'b0, 1'b0);
        drain("t1 drain");

        // T2: overfill a 4-deep FIFO; beat 5 stalls until one pop
        for (i = 1; i <= 4; i++) step("t2 fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
        step("t2 stall", 1'b1, 32'd5, 1'b1, 1'b0);
        chk("t2 full", 64'(full), 64'(1));
        chk("t2 dout1", 64'(dout), 64'(1));
        step("t2 pop", 1'b1, 32'd5, 1'b1, 1'b1);
        chk("t2 dout2", 64'(dout), 64'(2));
        step("t2 take5", 1'b1, 32'd5, 1'b1, 1'b0);
        chk("t2 beat5 accepted", 64'(last_acc), 64'(1));

        // T3: level 2 then 20 cycles of simultaneous push/pop
        step("t3 pop", 1'b0, '0, 1'b0, 1'b1);
        step("t3 pop", 1'b0, '0, 1'b0, 1'b1);
        for (i = 0; i < 20; i++) step("t3 stream", 1'b1, DATA_W'(100 + i), i == 19, 1'b1);
        chk("t3 level", 64'(level), 64'(2));
        drain("t3 drain");

        // T4: 7-beat then 3-beat packet
        d0 = done_seen;
        i = 0; g = 0;
        while (i < 7 && g < 40) begin
            step("t4 p7", 1'b1, DATA_W'(200 + i), i == 6, 1'b1);
            if (last_acc) i++;
            g++;
        end
        step("t4 gap", 1'b0, '0, 1'b0, 1'b1);
        chk("t4 pkt_beats 7", 64'(pkt_beats), 64'(7));
        i = 0;
        while (i < 3 && g < 80) begin
            step("t4 p3", 1'b1, DATA_W'(300 + i), i == 2, 1'b1);
            if (last_acc) i++;
            g++;
        end
        step("t4 gap2", 1'b0, '0, 1'b0, 1'b1);
        chk("t4 pkt_beats 3", 64'(pkt_beats), 64'(3));
        for (i = 0; i < 3; i++) step("t4 idle", 1'b0, '0, 1'b0, 1'b1);
        chk("t4 done pulses", 64'(done_seen - d0), 64'(2));
        chk("t4 budget", 64'(g < 80), 64'(1));
        drain("t4 drain");

        // T5: pop while empty
        step("t5 bad pop", 1'b0, '0, 1'b0, 1'b1);
        step("t5 after", 1'b0, '0, 1'b0, 1'b0);
        step("t5 sticky", 1'b0, '0, 1'b0, 1'b0);
        chk("t5 rd_err", 64'(rd_err), 64'(1));
        chk("t5 level", 64'(level), 64'(0));

        // T6: random traffic, reset mid-packet, random traffic again
        for (i = 0; i < 30; i++) begin
            rd = $urandom;
            step("t6 rand", 1'($urandom_range(1)), rd, ($urandom_range(7) == 0), 1'($urandom_range(1)));
        end
        g = 0;
        do begin
            step("t6 mid", 1'b1, 32'hDEAD_0000 + DATA_W'(g), 1'b0, 1'b0);
            g++;
        end while (!last_acc && g < 10);
        d0 = done_seen;
        do_reset("t6 reset");
        for (i = 0; i < 4; i++) step("t6 post", 1'b0, '0, 1'b0, 1'b0);
        chk("t6 no done after reset", 64'(done_seen - d0), 64'(0));
        for (i = 0; i < 30; i++) begin
            rd = $urandom;
            step("t6 rand2", 1'($urandom_range(1)), rd, ($urandom_range(7) == 0), 1'($urandom_range(1)));
        end
        drain("t6 drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
